// File: rtl/mem_pkg.sv
// mem_pkg: shared op encodings, fault causes, FSM states and size helper for mem_access_seq
package mem_pkg;
  localparam int OP_STORE_BIT = 2;
  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_INV = 2'b11;
  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_INVALID  = 2'b01,
    FC_MISALIGN = 2'b10,
    FC_RANGE    = 2'b11
  } fault_cause_t;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    return size == SIZE_B ? 3'd1 : size == SIZE_H ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_byte_array.sv
// mem_byte_array: single-port byte storage, synchronous write, asynchronous read
module mem_byte_array #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [7:0]           wr_data,
  output logic [7:0]           rd_data
);
  logic [7:0] mem [2**ADDR_BITS];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wr_data;
  assign rd_data = mem[addr];
endmodule

// File: rtl/mem_access_seq.sv
// mem_access_seq: handshaked byte-serial LB/LH/LW/SB/SH/SW unit with fault detection
module mem_access_seq
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] in,
  output logic [31:0] out,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_cause
);
  state_t state, next;
  fault_cause_t fc, cause;
  logic [2:0] op_q;
  logic uns_q;
  logic [ADDR_BITS-1:0] addr_q, baddr;
  logic [31:0] data_q, ld, ld_ext;
  logic [1:0] idx;
  logic last, we;
  logic [7:0] rd;
  always_comb begin
    cause = op[1:0] == SIZE_INV ? FC_INVALID
          : (op[1:0] == SIZE_H && addr[0]) || (op[1:0] == SIZE_W && addr[1:0] != 2'b00) ? FC_MISALIGN
          : |addr[31:ADDR_BITS] ? FC_RANGE : FC_NONE;
    last = idx == 2'(size_to_bytes(op_q[1:0]) - 3'd1);
    ld = out;
    ld[8*idx +: 8] = rd;
    // extension is folded into the edge that fetches the final byte
    ld_ext = !last ? ld
           : op_q[1:0] == SIZE_B ? {{24{~uns_q & ld[7]}}, ld[7:0]}
           : op_q[1:0] == SIZE_H ? {{16{~uns_q & ld[15]}}, ld[15:0]} : ld;
    next = state == IDLE ? (start ? (cause == FC_NONE ? ACCESS : DONE) : IDLE)
         : state == ACCESS ? (last ? DONE : ACCESS) : IDLE;
  end
  assign baddr = addr_q | ADDR_BITS'(idx);
  assign we = state == ACCESS && op_q[OP_STORE_BIT];
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign fault_cause = fc;
  mem_byte_array #(.ADDR_BITS(ADDR_BITS)) u_arr (
    .clk(clk),
    .we(we),
    .addr(baddr),
    .wr_data(data_q[8*idx +: 8]),
    .rd_data(rd)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      out    <= '0;
      fault  <= 1'b0;
      fc     <= FC_NONE;
      op_q   <= '0;
      uns_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      idx    <= '0;
    end else begin
      state <= next;
      if (state == IDLE && start) begin
        op_q   <= op;
        uns_q  <= load_unsigned;
        addr_q <= addr[ADDR_BITS-1:0];
        data_q <= in;
        idx    <= '0;
        out    <= '0;
        fault  <= cause != FC_NONE;
        fc     <= cause;
      end else if (state == ACCESS) begin
        idx <= idx + 2'd1;
        if (!op_q[OP_STORE_BIT]) out <= ld_ext;
      end
    end
  end
  assert property (@(posedge clk) disable iff (!reset_n) state == IDLE |-> !$isunknown({start, op}));
endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: table-driven scoreboard bench for mem_access_seq at ADDR_BITS 8 and 4
module tb_mem_access_seq;
  typedef struct {
    string       name;
    bit          sel;
    logic [2:0]  op;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] data;
    bit          poke;
    logic [31:0] exp_out;
    logic        exp_fault;
    logic [1:0]  exp_cause;
    int          lat;
  } vec_t;
  typedef struct {
    string       name;
    logic [31:0] out;
    logic        fault;
    logic [1:0]  cause;
    int          lat;
  } exp_t;

  logic clk = 1'b0, reset_n = 1'b0, start8 = 1'b0, start4 = 1'b0, uns = 1'b0;
  logic [2:0] op = 3'b000;
  logic [31:0] addr = '0, din = '0;
  logic [31:0] out8, out4;
  logic busy8, done8, fault8, busy4, done4, fault4;
  logic [1:0] fc8, fc4;
  exp_t sb_q[$];
  vec_t tbl[17];
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  mem_access_seq #(.ADDR_BITS(8)) u8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .op(op), .load_unsigned(uns),
    .addr(addr), .in(din), .out(out8), .busy(busy8), .done(done8),
    .fault(fault8), .fault_cause(fc8)
  );
  mem_access_seq #(.ADDR_BITS(4)) u4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .op(op), .load_unsigned(uns),
    .addr(addr), .in(din), .out(out4), .busy(busy4), .done(done4),
    .fault(fault4), .fault_cause(fc4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int edges, extra;
    exp_t e;
    @(negedge clk);
    op = v.op; uns = v.uns; addr = v.addr; din = v.data;
    if (v.sel) start4 = 1'b1; else start8 = 1'b1;
    sb_q.push_back('{v.name, v.exp_out, v.exp_fault, v.exp_cause, v.lat});
    @(posedge clk); #1;
    start8 = 1'b0; start4 = 1'b0; edges = 1;
    if (v.poke) begin
      start8 = 1'b1; op = 3'b100; addr = 32'h30; din = 32'hEE;
    end
    while (!(v.sel ? done4 : done8) && edges < 20) begin
      @(posedge clk); #1;
      start8 = 1'b0;
      edges++;
    end
    e = sb_q.pop_front();
    if (!(v.sel ? done4 : done8)) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: no done after %0d edges, expected at %0d", e.name, edges, e.lat);
    end else begin
      chk({e.name, " out"},   v.sel ? out4 : out8,     e.out);
      chk({e.name, " fault"}, v.sel ? fault4 : fault8, e.fault);
      chk({e.name, " cause"}, v.sel ? fc4 : fc8,       e.cause);
      chk({e.name, " lat"},   edges,                   e.lat);
    end
    @(posedge clk); #1;
    chk({e.name, " busy clr"}, v.sel ? busy4 : busy8, 1'b0);
    if (v.poke) begin
      extra = 0;
      repeat (6) begin @(posedge clk); #1; if (done8) extra++; end
      chk({e.name, " extra done"}, extra, 0);
      chk({e.name, " poke mem30"}, u8.u_arr.mem[8'h30], 8'h77);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{"sw20z",  0, 3'b110, 0, 32'h20,  32'h0,        0, 32'h0,        0, 2'b00, 5};
    tbl[1]  = '{"sw10",   0, 3'b110, 0, 32'h10,  32'h8899AABB, 0, 32'h0,        0, 2'b00, 5};
    tbl[2]  = '{"lw10",   0, 3'b010, 0, 32'h10,  32'h0,        0, 32'h8899AABB, 0, 2'b00, 5};
    tbl[3]  = '{"lb13",   0, 3'b000, 0, 32'h13,  32'h0,        0, 32'hFFFFFF88, 0, 2'b00, 2};
    tbl[4]  = '{"lbu13",  0, 3'b000, 1, 32'h13,  32'h0,        0, 32'h00000088, 0, 2'b00, 2};
    tbl[5]  = '{"lh12",   0, 3'b001, 0, 32'h12,  32'h0,        0, 32'hFFFF8899, 0, 2'b00, 3};
    tbl[6]  = '{"lhu12",  0, 3'b001, 1, 32'h12,  32'h0,        0, 32'h00008899, 0, 2'b00, 3};
    tbl[7]  = '{"sh11",   0, 3'b101, 0, 32'h11,  32'h1234,     0, 32'h0,        1, 2'b10, 1};
    tbl[8]  = '{"inv",    0, 3'b011, 0, 32'h10,  32'h0,        0, 32'h0,        1, 2'b01, 1};
    tbl[9]  = '{"lw100",  0, 3'b010, 0, 32'h100, 32'h0,        0, 32'h0,        1, 2'b11, 1};
    tbl[10] = '{"prio",   0, 3'b111, 0, 32'h101, 32'h0,        0, 32'h0,        1, 2'b01, 1};
    tbl[11] = '{"lwmis",  0, 3'b010, 0, 32'h12,  32'h0,        0, 32'h0,        1, 2'b10, 1};
    tbl[12] = '{"sb30",   0, 3'b100, 0, 32'h30,  32'h77,       0, 32'h0,        0, 2'b00, 2};
    tbl[13] = '{"lwpoke", 0, 3'b010, 0, 32'h10,  32'h0,        1, 32'h8899AABB, 0, 2'b00, 5};
    tbl[14] = '{"sb4f",   1, 3'b100, 0, 32'hF,   32'h5A,       0, 32'h0,        0, 2'b00, 2};
    tbl[15] = '{"lbu4f",  1, 3'b000, 1, 32'hF,   32'h0,        0, 32'h0000005A, 0, 2'b00, 2};
    tbl[16] = '{"sb4rng", 1, 3'b100, 0, 32'h10,  32'hA5,       0, 32'h0,        1, 2'b11, 1};

    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    chk("rst busy8",  busy8,  1'b0);
    chk("rst done8",  done8,  1'b0);
    chk("rst out8",   out8,   32'h0);
    chk("rst fault8", fault8, 1'b0);
    chk("rst cause8", fc8,    2'b00);
    chk("rst busy4",  busy4,  1'b0);
    chk("rst out4",   out4,   32'h0);

    for (int i = 0; i < 17; i++) run(tbl[i]);

    chk("sh11 mem11", u8.u_arr.mem[8'h11], 8'hAA);
    chk("sh11 mem12", u8.u_arr.mem[8'h12], 8'h99);

    @(negedge clk);
    op = 3'b110; addr = 32'h20; din = 32'h44332211; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    chk("abort busy before", busy8, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("abort busy",  busy8,  1'b0);
    chk("abort done",  done8,  1'b0);
    chk("abort out",   out8,   32'h0);
    chk("abort fault", fault8, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    chk("abort mem20", u8.u_arr.mem[8'h20], 8'h11);
    chk("abort mem21", u8.u_arr.mem[8'h21], 8'h00);
    chk("abort mem22", u8.u_arr.mem[8'h22], 8'h00);
    chk("abort mem23", u8.u_arr.mem[8'h23], 8'h00);
    run('{"lw20", 0, 3'b010, 0, 32'h20, 32'h0, 0, 32'h00000011, 0, 2'b00, 5});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Parametrised, handshaked successor to the single-cycle memory access unit.
- Performs LB/LH/LW (signed or unsigned) and SB/SH/SW against an internal byte-wide array of 2**ADDR_BITS bytes, one byte per cycle, under a small FSM.
- Adds start/busy/done handshake, sign extension, out-of-range detection and an encoded fault cause.
- Sits between the core's execute stage and the data-memory model.

Parameters:
- ADDR_BITS, 8, log2 of array depth in bytes; legal range 2..16.

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request strobe; sampled only in IDLE
- op  in  3  op[2]=store; op[1:0]: 00 byte, 01 half, 10 word, 11 invalid
- load_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend; ignored for stores
- addr  in  32  byte address
- in  in  32  store data, little-endian
- out  out  32  load result; held from done until the next accepted start
- busy  out  1  high from the accepting edge until done deasserts
- done  out  1  single-cycle completion pulse
- fault  out  1  completed access faulted; valid with done, held like out
- fault_cause  out  2  00 none, 01 invalid op, 10 misaligned, 11 out of range

Behaviour:
- Reset (async assert, sync release): state=IDLE; out=0, busy=0, done=0, fault=0, fault_cause=0. Array contents are NOT reset.
- FSM states are IDLE, ACCESS, DONE.
- IDLE, start=1 at edge E0:
  - latch op, addr, in, load_unsigned; busy=1; out cleared to 0.
  - N = 1/2/4 bytes for size 00/01/10.
  - fault check, priority invalid > misaligned > range:
    - invalid: op[1:0]==11
    - misaligned: half with addr[0]=1, or word with addr[1:0]!=0
    - range: addr[31:ADDR_BITS] != 0
  - faulting: go to DONE with fault=1 and fault_cause set; no array write, out stays 0.
  - otherwise: go to ACCESS with idx=0, fault=0, fault_cause=00.
- ACCESS, one byte per edge; byte address = latched addr[ADDR_BITS-1:0] | idx (aligned, so OR is exact):
  - store: array[byte addr] <= in[8*idx+7 : 8*idx]
  - load: out[8*idx+7 : 8*idx] <= array[byte addr] (asynchronous array read)
  - idx increments; at the edge processing idx=N-1, go to DONE.
  - the same edge applies the extension: bits [31:8N] = 0 if load_unsigned, else the copy of bit 8N-1; no extension when N=4.
- DONE: done=1 for exactly one cycle, busy stays 1; next edge returns to IDLE with busy=0, done=0.
- Latency, start edge to done-high cycle:
  - N+1 edges for a good access: LB 2, LH 3, LW 5
  - 1 edge for a fault
- start while busy=1 is ignored and not queued. A start in the cycle after DONE (state IDLE) is accepted.
- Stores leave out at 0.
- Reset mid-ACCESS aborts immediately. Bytes already written by a store remain; later bytes are untouched. No done is issued.
- idx is a 2-bit counter and never wraps within an access (max 3).
- Synthesis asserts guard against X on start/op during IDLE.

Decomposition:
- Package mem_pkg holds:
  - op field constants (OP_STORE_BIT, SIZE_B/H/W/INV)
  - fault_cause_t enum
  - state_t enum {IDLE, ACCESS, DONE}
  - function size_to_bytes
- One sub-module, mem_byte_array: ADDR_BITS-parametrised byte storage with synchronous write, asynchronous read and a single port; it exposes the array public for bench backdoor checks.

Test Plan:
- Reset, then SW addr=0x10 in=0x8899AABB, then LW addr=0x10 → done 5 edges after start, out=0x8899AABB, fault=0, fault_cause=00.
- LB addr=0x13 signed → out=0xFFFFFF88; LBU → 0x00000088; LH addr=0x12 signed → 0xFFFF8899; LHU → 0x00008899.
- SH addr=0x11 → done after 1 edge, fault=1, cause=10, memory unchanged. op=011 → cause=01. LW addr=0x100 (ADDR_BITS=8) → cause=11. op=111 with addr=0x101 → cause=01 (priority).
- Pulse start again during a busy LW → ignored; exactly one done; the second request's addr is never accessed.
- Assert reset_n low on the 2nd ACCESS edge of SW addr=0x20 in=0x44332211 over a known 0x00000000 → outputs reset immediately; backdoor shows byte 0x20=0x11 and bytes 0x21–0x23 unchanged.
- With ADDR_BITS=4: SB addr=0xF in=0x5A then LBU addr=0xF → out=0x5A; SB addr=0x10 → cause=11.
